rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback sources: ALU writeback and memory-load writeback.
- Each source uses a valid/ready handshake. The block applies two-state round-robin priority, drops writes to register 0, registers the selected write onto the port, and counts cycles where both sources collide.
- Sits between the execute/memory writeback stages and the three-ported register file.

Parameters:
- DW, 32, data width of wd3 and of both source data buses
- AW, 5, register address width (32 registers)
- CW, 16, width of the saturating conflict counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU source has a write pending
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU write data
- alu_ready  out  1  ALU write accepted this cycle
- mem_valid  in  1  load source has a write pending
- mem_addr  in  AW  load destination register
- mem_data  in  DW  load write data
- mem_ready  out  1  load write accepted this cycle
- we3  out  1  register-file write enable (registered)
- wa3  out  AW  register-file write address (registered)
- wd3  out  DW  register-file write data (registered)
- conflict_cnt  out  CW  count of cycles with both valids high (saturating)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: we3=0, wa3=0, wd3=0, conflict_cnt=0, priority state=PRIO_ALU. While reset is high, alu_ready=0 and mem_ready=0.
- Priority state machine: two states, PRIO_ALU and PRIO_MEM.
  - Single request: the requesting source is granted, regardless of state.
  - Both valid in PRIO_ALU: ALU is granted and the next state is PRIO_MEM.
  - Both valid in PRIO_MEM: MEM is granted and the next state is PRIO_ALU.
  - A grant with no contention leaves the state unchanged.
  - No valid: state holds.
- Ready: alu_ready and mem_ready are combinational from the valids and the priority state.
  - At most one ready is high per cycle.
  - ready is high only when the matching valid is high and reset is low.
  - A handshake completes in any cycle where valid && ready.
- Source obligations: addr and data stay stable, and valid stays high, until ready. A source may deassert valid only after its handshake completes.
- Write latency: exactly one cycle.
  - The granted addr and data are captured at the edge ending the handshake cycle.
  - we3 is high for exactly one cycle after the handshake; wa3/wd3 hold the captured values.
  - When no handshake occurs, we3=0 the next cycle and wa3/wd3 hold their previous values.
- Register 0 writes: a handshake with addr==0 completes normally (ready=1), but we3 stays 0 the next cycle. The write is silently dropped and the round-robin update still applies.
- Throughput: one write per cycle. Back-to-back handshakes produce we3 high on consecutive cycles.
- conflict_cnt: increments on each cycle with alu_valid && mem_valid and reset low. It saturates at 2^CW-1 and never wraps.
- Reset mid-operation: a pending source stays unaccepted and must keep valid high. A write captured in the cycle before reset still appears on the port, because reset clears we3 at the following edge. After reset deasserts, arbitration restarts in PRIO_ALU.
- Same destination from both sources: no merging. The two writes are issued in grant order on successive cycles, and the later grant wins in the register file.

Decomposition:
- Shared package rf_pkg:
  - Constants for register-file data width (32) and address width (5).
  - Constant REG_ZERO = 5'd0.
  - Enum typedef for the priority state: PRIO_ALU, PRIO_MEM.
- Sub-module: rr_arb2, a two-requester round-robin grant with its priority flop.
- Everything else (write-port registers, zero filter, conflict counter) lives in rf_wb_arbiter.

Test Plan:
- ALU only: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF for one cycle → alu_ready=1 that cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF; the cycle after, we3=0.
- Contention alternation: both valid for 4 cycles after reset, with ALU addresses 1/2 and MEM addresses 3/4 presented in order (each source advances after its handshake) → grants ALU, MEM, ALU, MEM; wa3 sequence 1, 3, 2, 4; conflict_cnt=4.
- Register 0 drop: mem_valid=1, mem_addr=0, mem_data=0x1234 → mem_ready=1; next cycle we3=0; wa3/wd3 unchanged.
- Saturation: CW=4, both valid for 20 cycles → conflict_cnt stops at 15 and stays 15.
- Reset mid-operation: both valid, assert reset for 2 cycles → readies=0 during reset; we3=0 and conflict_cnt=0 after reset; the first grant after reset goes to ALU.
- Back-to-back: MEM only, addresses 7, 8, 9 on consecutive cycles → we3 high 3 consecutive cycles, wa3=7, 8, 9; priority state unchanged (PRIO_ALU).

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback priority state type.
package rf_pkg;

    localparam int unsigned RF_DW = 32;
    localparam int unsigned RF_AW = 5;

    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; priority flips only when both requesters collide.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    prio_e state_q;
    prio_e state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRIO_ALU;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are masked during reset so no handshake can complete.
    always_comb begin
        state_d = state_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        if (!reset) begin
            if (req_a && req_b) begin
                if (state_q == PRIO_ALU) begin
                    gnt_a   = 1'b1;
                    state_d = PRIO_MEM;
                end else begin
                    gnt_b   = 1'b1;
                    state_d = PRIO_ALU;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback,
// dropping writes to r0 and counting cycles where both sources collide.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DW = RF_DW,
    parameter int unsigned AW = RF_AW,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic [CW-1:0] conflict_cnt
);

    logic          hs;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          wr_ok;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (alu_valid),
        .req_b (mem_valid),
        .gnt_a (alu_ready),
        .gnt_b (mem_ready)
    );

    always_comb begin
        hs       = alu_ready || mem_ready;
        sel_addr = alu_ready ? alu_addr : mem_addr;
        sel_data = alu_ready ? alu_data : mem_data;
        wr_ok    = hs && (sel_addr != AW'(REG_ZERO));
    end

    // Dropped r0 writes leave wa3/wd3 holding the last real write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= wr_ok;
            if (wr_ok) begin
                wa3 <= sel_addr;
                wd3 <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (alu_valid && mem_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter; a CW=4 instance on the same inputs covers saturation.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [15:0] conflict_cnt;

    logic        s_alu_ready;
    logic        s_mem_ready;
    logic        s_we3;
    logic [4:0]  s_wa3;
    logic [31:0] s_wd3;
    logic [3:0]  s_conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(32), .AW(5), .CW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .conflict_cnt (conflict_cnt)
    );

    rf_wb_arbiter #(.DW(32), .AW(5), .CW(4)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (s_alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (s_mem_ready),
        .we3          (s_we3),
        .wa3          (s_wa3),
        .wd3          (s_wd3),
        .conflict_cnt (s_conflict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        tick();
        tick();
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_ardy", alu_ready, 0);
        reset = 1'b0;

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("alu_rdy", alu_ready, 1);
        check("alu_mrdy", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        check("alu_we3", we3, 1);
        check("alu_wa3", wa3, 5);
        check("alu_wd3", wd3, 32'hDEADBEEF);
        tick();
        check("alu_we3_off", we3, 0);
        check("alu_wa3_hold", wa3, 5);

        // Contention alternation: ALU 1,2,(10) vs MEM 3,4
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
        #1;
        check("c1_ardy", alu_ready, 1);
        check("c1_mrdy", mem_ready, 0);
        tick();
        alu_addr = 5'd2; alu_data = 32'h22;
        #1;
        check("c2_mrdy", mem_ready, 1);
        check("c2_ardy", alu_ready, 0);
        check("c2_wa3", wa3, 1);
        check("c2_wd3", wd3, 32'h11);
        tick();
        mem_addr = 5'd4; mem_data = 32'h44;
        #1;
        check("c3_ardy", alu_ready, 1);
        check("c3_wa3", wa3, 3);
        check("c3_wd3", wd3, 32'h33);
        tick();
        alu_addr = 5'd10; alu_data = 32'hAA;
        #1;
        check("c4_mrdy", mem_ready, 1);
        check("c4_wa3", wa3, 2);
        tick();
        mem_valid = 1'b0;
        #1;
        check("c5_ardy", alu_ready, 1);
        check("c5_wa3", wa3, 4);
        check("c5_cnt", conflict_cnt, 4);
        tick();
        alu_valid = 1'b0;
        check("c6_wa3", wa3, 10);
        check("c6_we3", we3, 1);

        // Register 0 write is accepted but dropped
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
        #1;
        check("r0_mrdy", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("r0_we3", we3, 0);
        check("r0_wa3", wa3, 10);
        check("r0_wd3", wd3, 32'hAA);

        // Back-to-back MEM writes 7, 8, 9
        mem_valid = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            mem_addr = 5'(i); mem_data = 32'(i * 256);
            #1;
            check("b2b_mrdy", mem_ready, 1);
            tick();
            check("b2b_we3", we3, 1);
            check("b2b_wa3", wa3, 64'(i));
            check("b2b_wd3", wd3, 64'(i * 256));
        end
        // Priority must still favour ALU
        alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hB11;
        mem_addr  = 5'd12; mem_data = 32'hC12;
        #1;
        check("b2b_prio_ardy", alu_ready, 1);
        check("b2b_prio_mrdy", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("b2b_m12_rdy", mem_ready, 1);
        check("b2b_wa3_11", wa3, 11);
        tick();
        mem_valid = 1'b0;
        check("b2b_wa3_12", wa3, 12);
        check("b2b_cnt", conflict_cnt, 5);

        // Reset mid-operation (state is PRIO_MEM here)
        alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hD13;
        #1;
        check("pre_rst_ardy", alu_ready, 1);
        tick();
        reset = 1'b1;
        alu_addr = 5'd15; alu_data = 32'hF15;
        mem_valid = 1'b1; mem_addr = 5'd14; mem_data = 32'hE14;
        #1;
        check("rst1_ardy", alu_ready, 0);
        check("rst1_mrdy", mem_ready, 0);
        check("rst1_we3", we3, 1);
        check("rst1_wa3", wa3, 13);
        tick();
        check("rst2_ardy", alu_ready, 0);
        check("rst2_mrdy", mem_ready, 0);
        check("rst2_we3", we3, 0);
        check("rst2_cnt", conflict_cnt, 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_we3", we3, 0);
        check("post_rst_cnt", conflict_cnt, 0);
        check("post_rst_ardy", alu_ready, 1);
        check("post_rst_mrdy", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("post_rst_cnt1", conflict_cnt, 1);
        check("post_rst_wa3", wa3, 15);
        check("post_rst_m_rdy", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("post_rst_wa3_m", wa3, 14);
        check("post_rst_wd3_m", wd3, 32'hE14);

        // Saturation of the CW=4 instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat_start", s_conflict_cnt, 0);
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", s_conflict_cnt, 14);
            if (i == 15) check("sat_15", s_conflict_cnt, 15);
        end
        check("sat_20", s_conflict_cnt, 15);
        check("wide_20", conflict_cnt, 20);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        check("sat_hold", s_conflict_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
